// File: rtl/smg_pkg.sv
// ----------------------------------------------------------------------------
// smg_pkg
// Shared definitions for the seven-segment scan controller:
//   smg_state_e   - scan FSM state encoding (IDLE / BLANK / SHOW)
//   SMG_BLANK_SEG - segment byte that drives every segment off
//   SMG_DIG_MAX   - largest supported digit count
//   SMG_CNT_W     - width of the phase counter
//   SMG_PTR_W     - width of a digit index (covers SMG_DIG_MAX digits)
// ----------------------------------------------------------------------------
package smg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } smg_state_e;

    localparam logic [7:0] SMG_BLANK_SEG = 8'hFF;
    localparam int         SMG_DIG_MAX   = 8;
    localparam int         SMG_CNT_W     = 19;
    localparam int         SMG_PTR_W     = $clog2(SMG_DIG_MAX);

endpackage

// File: rtl/smg_scan_controller_if.sv
// ----------------------------------------------------------------------------
// smg_scan_controller_if
// Bundles the frame-update handshake and the display pins of the scan
// controller.
//   Digit_Data      - segment byte per digit, digit i at [8i+7:8i]
//   Digit_En        - per-digit enable mask
//   Update_Req      - level request to load Digit_Data/Digit_En
//   Update_Ack      - one-cycle acknowledge, shadow loaded on that edge
//   Column_Scan_Sig - active-low one-hot digit select
//   Row_Scan_Sig    - segment data to the pins
//   Frame_Done      - one-cycle pulse at the end of each frame
//   Brightness      - 4-bit lit-time fraction (only with BRIGHTNESS_EN)
// Modports: master = frame source / pin observer, slave = controller.
// Optional feature macro: BRIGHTNESS_EN
// ----------------------------------------------------------------------------
interface smg_scan_controller_if #(
    parameter int DIGITS = 4
) ();

    logic [8*DIGITS-1:0] Digit_Data;
    logic [DIGITS-1:0]   Digit_En;
    logic                Update_Req;
    logic                Update_Ack;
    logic [DIGITS-1:0]   Column_Scan_Sig;
    logic [7:0]          Row_Scan_Sig;
    logic                Frame_Done;
`ifdef BRIGHTNESS_EN
    logic [3:0]          Brightness;

    modport master (
        output Digit_Data, Digit_En, Update_Req, Brightness,
        input  Update_Ack, Column_Scan_Sig, Row_Scan_Sig, Frame_Done
    );
    modport slave (
        input  Digit_Data, Digit_En, Update_Req, Brightness,
        output Update_Ack, Column_Scan_Sig, Row_Scan_Sig, Frame_Done
    );
`else
    modport master (
        output Digit_Data, Digit_En, Update_Req,
        input  Update_Ack, Column_Scan_Sig, Row_Scan_Sig, Frame_Done
    );
    modport slave (
        input  Digit_Data, Digit_En, Update_Req,
        output Update_Ack, Column_Scan_Sig, Row_Scan_Sig, Frame_Done
    );
`endif

endinterface

// File: rtl/smg_next_digit.sv
// ----------------------------------------------------------------------------
// smg_next_digit
// Combinational search over the digit-enable mask.
//   mask_i - enabled digits
//   ptr_i  - digit currently shown
//   next_o - lowest enabled index above ptr_i (0 when none)
//   wrap_o - 1 when no enabled index lies above ptr_i (frame boundary)
//   low_o  - lowest enabled index in the mask (0 when mask is empty)
// ----------------------------------------------------------------------------
module smg_next_digit
    import smg_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic [DIGITS-1:0]    mask_i,
    input  logic [SMG_PTR_W-1:0] ptr_i,
    output logic [SMG_PTR_W-1:0] next_o,
    output logic                 wrap_o,
    output logic [SMG_PTR_W-1:0] low_o
);

    // Descending scan: the last hit written is the lowest qualifying index.
    always_comb begin
        next_o = '0;
        wrap_o = 1'b1;
        low_o  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                low_o = SMG_PTR_W'(i);
                if (SMG_PTR_W'(i) > ptr_i) begin
                    next_o = SMG_PTR_W'(i);
                    wrap_o = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/smg_scan_controller.sv
// ----------------------------------------------------------------------------
// smg_scan_controller
// Time-multiplexed scan scheduler for a multi-digit seven-segment display.
// Shadows per-digit segment bytes and an enable mask, walks the enabled digits
// in ascending order with a blanking gap before each one, and accepts new
// frames through a req/ack handshake only in IDLE or at a frame boundary.
// Ports:
//   CLK   - system clock
//   RST_N - asynchronous active-low reset
//   bus   - smg_scan_controller_if.slave (handshake, frame data, pins)
// Parameters: DIGITS (1..8), SCAN_TICKS / BLANK_TICKS (phase length - 1).
// Optional feature macro: BRIGHTNESS_EN (adds bus.Brightness, PWM within SHOW)
// ----------------------------------------------------------------------------
module smg_scan_controller
    import smg_pkg::*;
#(
    parameter int                   DIGITS      = 4,
    parameter logic [SMG_CNT_W-1:0] SCAN_TICKS  = 19'd49_999,
    parameter logic [SMG_CNT_W-1:0] BLANK_TICKS = 19'd999
) (
    input logic                  CLK,
    input logic                  RST_N,
    smg_scan_controller_if.slave bus
);

    smg_state_e           state_q, state_d;
    logic [SMG_PTR_W-1:0] ptr_q, ptr_d;
    logic [SMG_CNT_W-1:0] cnt_q, cnt_d;
    logic [8*DIGITS-1:0]  data_q, data_d;
    logic [DIGITS-1:0]    en_q, en_d;
    logic                 first_q, first_d;
    logic                 ack_q, ack_d;
    logic                 done_q, done_d;
    logic [DIGITS-1:0]    col_q, col_d;
    logic [7:0]           row_q, row_d;

    logic                 req_ok;
    logic                 load;
    logic                 lit;
    logic [SMG_PTR_W-1:0] next_idx;
    logic [SMG_PTR_W-1:0] low_idx;
    logic                 wrap;

`ifdef BRIGHTNESS_EN
    logic [23:0] thr_q, thr_d;

    // Lit window in SHOW: ((SCAN_TICKS+1) * (b+1)) >> 4, 24 bits never wrap.
    function automatic logic [23:0] lit_limit(input logic [3:0] b);
        logic [23:0] prod;
        prod = (24'(SCAN_TICKS) + 24'd1) * (24'(b) + 24'd1);
        return prod >> 4;
    endfunction
`endif

    smg_next_digit #(
        .DIGITS (DIGITS)
    ) u_next (
        .mask_i (en_q),
        .ptr_i  (ptr_q),
        .next_o (next_idx),
        .wrap_o (wrap),
        .low_o  (low_idx)
    );

    // A request is taken only once per assertion: the cycle after an Ack the
    // requester may still be holding Update_Req.
    assign req_ok = bus.Update_Req && !ack_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        en_d    = en_q;
        first_d = first_q;
        ack_d   = 1'b0;
        done_d  = 1'b0;
        load    = 1'b0;
`ifdef BRIGHTNESS_EN
        thr_d   = thr_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (en_q != '0) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    first_d = 1'b1;
                end else if (req_ok) begin
                    load = 1'b1;
                end
            end
            BLANK: begin
                // The first BLANK of a frame picks the lowest digit from the
                // shadow mask, which by now already holds any freshly loaded
                // enable; this keeps the finder off the raw input mask.
                if (first_q) begin
                    ptr_d = low_idx;
                end
                if (cnt_q == BLANK_TICKS) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                    first_d = 1'b0;
`ifdef BRIGHTNESS_EN
                    thr_d   = lit_limit(bus.Brightness);
`endif
                end else begin
                    cnt_d = cnt_q + SMG_CNT_W'(1);
                end
            end
            SHOW: begin
                if (cnt_q == SCAN_TICKS) begin
                    cnt_d = '0;
                    if (!wrap) begin
                        ptr_d   = next_idx;
                        state_d = BLANK;
                    end else begin
                        done_d = 1'b1;
                        load   = req_ok;
                        if ((req_ok ? bus.Digit_En : en_q) == '0) begin
                            state_d = IDLE;
                        end else begin
                            state_d = BLANK;
                            first_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + SMG_CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            data_d = bus.Digit_Data;
            en_d   = bus.Digit_En;
            ack_d  = 1'b1;
        end

`ifdef BRIGHTNESS_EN
        lit = ({5'd0, cnt_d} < thr_d);
`else
        lit = 1'b1;
`endif

        // Pins are decoded from the next state so they line up with it.
        col_d = '1;
        row_d = SMG_BLANK_SEG;
        if (state_d == SHOW && lit) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (ptr_d == SMG_PTR_W'(i)) begin
                    col_d[i] = 1'b0;
                    row_d    = data_q[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            en_q    <= '0;
            first_q <= 1'b0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            col_q   <= '1;
            row_q   <= SMG_BLANK_SEG;
`ifdef BRIGHTNESS_EN
            thr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            en_q    <= en_d;
            first_q <= first_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            col_q   <= col_d;
            row_q   <= row_d;
`ifdef BRIGHTNESS_EN
            thr_q   <= thr_d;
`endif
        end
    end

    assign bus.Update_Ack      = ack_q;
    assign bus.Frame_Done      = done_q;
    assign bus.Column_Scan_Sig = col_q;
    assign bus.Row_Scan_Sig    = row_q;

endmodule

// File: tb/tb_smg_scan_controller.sv
// ----------------------------------------------------------------------------
// tb_smg_scan_controller
// Randomized self-checking bench for smg_scan_controller (DIGITS=4,
// SCAN_TICKS=9, BLANK_TICKS=1). The reference keeps the shadow frame and a
// queue of the pin values for the remainder of the current frame: each frame
// is 2 blank cycles + 10 lit cycles per enabled digit, ascending.
// ----------------------------------------------------------------------------
module tb_smg_scan_controller;

    localparam int DIGITS = 4;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    smg_scan_controller_if #(.DIGITS(DIGITS)) bus ();

    smg_scan_controller #(
        .DIGITS      (DIGITS),
        .SCAN_TICKS  (19'd9),
        .BLANK_TICKS (19'd1)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] col;
        logic [7:0] row;
    } slot_t;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    slot_t       fq[$];
    int          done_cyc[$];
    bit          m_run;
    logic [3:0]  m_en;
    logic [31:0] m_data;
    logic        m_ack_prev;
    logic [13:0] exp_v;
    logic [13:0] obs_v;

    function automatic void model_reset();
        fq.delete();
        m_run      = 1'b0;
        m_en       = '0;
        m_data     = '0;
        m_ack_prev = 1'b0;
        exp_v      = {4'hF, 8'hFF, 2'b00};
    endfunction

    function automatic void build_frame();
        slot_t s;
        for (int d = 0; d < DIGITS; d++) begin
            if (m_en[d]) begin
                for (int k = 0; k < 2; k++) begin
                    s.col = 4'hF;
                    s.row = 8'hFF;
                    fq.push_back(s);
                end
                for (int k = 0; k < 10; k++) begin
                    s.col = 4'hF & ~(4'b0001 << d);
                    s.row = m_data[8*d +: 8];
                    fq.push_back(s);
                end
            end
        end
    endfunction

    // Advance the reference by one clock edge given the inputs seen at it.
    function automatic void model_edge(input logic req, input logic [31:0] dd,
                                       input logic [3:0] de);
        logic  ack;
        logic  done;
        slot_t cur;
        ack  = 1'b0;
        done = 1'b0;
        if (m_run && fq.size() == 0) begin
            done = 1'b1;
            if (req && !m_ack_prev) begin
                m_en   = de;
                m_data = dd;
                ack    = 1'b1;
            end
            if (m_en == 4'h0) m_run = 1'b0;
            else              build_frame();
        end else if (!m_run) begin
            if (m_en != 4'h0) begin
                m_run = 1'b1;
                build_frame();
            end else if (req && !m_ack_prev) begin
                m_en   = de;
                m_data = dd;
                ack    = 1'b1;
            end
        end
        cur.col = 4'hF;
        cur.row = 8'hFF;
        if (m_run) cur = fq.pop_front();
        m_ack_prev = ack;
        exp_v = {cur.col, cur.row, ack, done};
    endfunction

    // One clock: update the reference, sample the pins 1 ns after the edge,
    // and let the requester drop its request once the acknowledge is due.
    task automatic step();
        @(posedge CLK);
        model_edge(bus.Update_Req, bus.Digit_Data, bus.Digit_En);
        #1;
        cyc++;
        obs_v = {bus.Column_Scan_Sig, bus.Row_Scan_Sig, bus.Update_Ack, bus.Frame_Done};
        if (bus.Frame_Done === 1'b1) done_cyc.push_back(cyc);
        if (exp_v[1]) bus.Update_Req = 1'b0;
    endtask

    task automatic request(input logic [31:0] dd, input logic [3:0] de);
        bus.Digit_Data = dd;
        bus.Digit_En   = de;
        bus.Update_Req = 1'b1;
    endtask

    task automatic test_reset();
        bus.Digit_Data = '0;
        bus.Digit_En   = '0;
        bus.Update_Req = 1'b0;
        RST_N = 1'b0;
        repeat (3) begin
            @(posedge CLK);
            #1;
            vectors += 4;
            if (bus.Column_Scan_Sig !== 4'hF) begin miscompares++; $display("FAIL reset_col got %b want 1111", bus.Column_Scan_Sig); end
            if (bus.Row_Scan_Sig !== 8'hFF) begin miscompares++; $display("FAIL reset_row got %h want ff", bus.Row_Scan_Sig); end
            if (bus.Update_Ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack got %b want 0", bus.Update_Ack); end
            if (bus.Frame_Done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", bus.Frame_Done); end
        end
        @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            step(); vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL idle_after_reset cyc=%0d col,row,ack,done got %h want %h", cyc, obs_v, exp_v); end
        end
    endtask

    task automatic test_full_frame();
        int n;
        request(32'hB0A4F9C0, 4'hF);
        done_cyc.delete();
        for (int i = 0; i < 2 + 48*3; i++) begin
            step(); vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL full_frame cyc=%0d col,row,ack,done got %h want %h", cyc, obs_v, exp_v); end
        end
        n = done_cyc.size();
        vectors++;
        if (n < 2) begin
            miscompares++; $display("FAIL full_frame_done_count got %0d want >=2", n);
        end else begin
            for (int i = 1; i < n; i++) begin
                vectors++;
                if (done_cyc[i] - done_cyc[i-1] != 48) begin miscompares++; $display("FAIL full_frame_period got %0d want 48", done_cyc[i] - done_cyc[i-1]); end
            end
        end
    endtask

    task automatic test_sparse_enable();
        int bad = 0;
        int n;
        request($urandom, 4'b0101);
        for (int i = 0; i < 50; i++) begin
            step(); vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL sparse_load cyc=%0d col,row,ack,done got %h want %h", cyc, obs_v, exp_v); end
        end
        done_cyc.delete();
        for (int i = 0; i < 24*4; i++) begin
            step(); vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL sparse cyc=%0d col,row,ack,done got %h want %h", cyc, obs_v, exp_v); end
            if (obs_v[13:10] == 4'b1101 || obs_v[13:10] == 4'b0111) bad++;
        end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL sparse_disabled_columns got %0d cycles want 0", bad); end
        n = done_cyc.size();
        vectors++;
        if (n < 3) begin
            miscompares++; $display("FAIL sparse_done_count got %0d want >=3", n);
        end else begin
            vectors++;
            if (done_cyc[n-1] - done_cyc[n-2] != 24) begin miscompares++; $display("FAIL sparse_period got %0d want 24", done_cyc[n-1] - done_cyc[n-2]); end
        end
    endtask

    task automatic test_mid_frame_update();
        for (int r = 0; r < 4; r++) begin
            int wait_n;
            wait_n = $urandom_range(3, 40);
            for (int i = 0; i < wait_n; i++) begin
                step(); vectors++;
                if (obs_v !== exp_v) begin miscompares++; $display("FAIL mid_update_pre cyc=%0d col,row,ack,done got %h want %h", cyc, obs_v, exp_v); end
            end
            request($urandom, 4'($urandom_range(1, 15)));
            for (int i = 0; i < 110; i++) begin
                step(); vectors++;
                if (obs_v !== exp_v) begin miscompares++; $display("FAIL mid_update cyc=%0d col,row,ack,done got %h want %h", cyc, obs_v, exp_v); end
            end
        end
    endtask

    task automatic test_random_updates();
        for (int r = 0; r < 8; r++) begin
            int          wait_n;
            logic [3:0]  en;
            wait_n = $urandom_range(0, 60);
            en     = (r % 4 == 1) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            for (int i = 0; i < wait_n; i++) begin
                step(); vectors++;
                if (obs_v !== exp_v) begin miscompares++; $display("FAIL random_pre cyc=%0d col,row,ack,done got %h want %h", cyc, obs_v, exp_v); end
            end
            request($urandom, en);
            for (int i = 0; i < 100; i++) begin
                step(); vectors++;
                if (obs_v !== exp_v) begin miscompares++; $display("FAIL random cyc=%0d en=%b col,row,ack,done got %h want %h", cyc, en, obs_v, exp_v); end
            end
        end
    endtask

    task automatic test_disable();
        request($urandom, 4'hF);
        for (int i = 0; i < 60; i++) begin
            step(); vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL disable_load cyc=%0d col,row,ack,done got %h want %h", cyc, obs_v, exp_v); end
        end
        request($urandom, 4'h0);
        for (int i = 0; i < 90; i++) begin
            step(); vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL disable cyc=%0d col,row,ack,done got %h want %h", cyc, obs_v, exp_v); end
        end
        vectors++;
        if ({bus.Column_Scan_Sig, bus.Row_Scan_Sig} !== 12'hFFF) begin
            miscompares++; $display("FAIL disable_idle got %b/%h want 1111/ff", bus.Column_Scan_Sig, bus.Row_Scan_Sig);
        end
    endtask

    task automatic test_reset_mid_show();
        bit hit = 1'b0;
        request($urandom, 4'hF);
        for (int i = 0; i < 200 && !hit; i++) begin
            step(); vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL reset_mid_run cyc=%0d col,row,ack,done got %h want %h", cyc, obs_v, exp_v); end
            if (exp_v[13:10] == 4'b1011) hit = 1'b1;
        end
        vectors++;
        if (!hit) begin
            miscompares++; $display("FAIL reset_mid_reach got no digit-2 SHOW within 200 cycles want reached");
        end else begin
            #2;
            RST_N = 1'b0;
            #1;
            vectors++;
            if ({bus.Column_Scan_Sig, bus.Row_Scan_Sig, bus.Update_Ack, bus.Frame_Done} !== 14'h3FFC) begin
                miscompares++; $display("FAIL reset_async got %h want 3ffc",
                    {bus.Column_Scan_Sig, bus.Row_Scan_Sig, bus.Update_Ack, bus.Frame_Done});
            end
        end
        RST_N = 1'b0;
        bus.Update_Req = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
        for (int i = 0; i < 30; i++) begin
            step(); vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL reset_mid_idle cyc=%0d col,row,ack,done got %h want %h", cyc, obs_v, exp_v); end
        end
        request($urandom, 4'($urandom_range(1, 15)));
        for (int i = 0; i < 80; i++) begin
            step(); vectors++;
            if (obs_v !== exp_v) begin miscompares++; $display("FAIL reset_mid_restart cyc=%0d col,row,ack,done got %h want %h", cyc, obs_v, exp_v); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_frame();
        test_sparse_enable();
        test_mid_frame_update();
        test_random_updates();
        test_disable();
        test_reset_mid_show();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
